// File: rtl/mul_add_pkg.sv
// Shared helpers for mul_add_pipe: sum width, per-width range limits and the
// overflow range check used when the exact sum is narrowed to the output width.
// Limits are held in a fixed signed container, wide enough for operands up to MAX_W bits.
package mul_add_pkg;

    localparam int unsigned MAX_W = 64;
    localparam int unsigned LIM_W = 2 * MAX_W + 2;

    typedef logic signed [LIM_W-1:0] lim_t;

    // Width of the exact a*b + c result
    function automatic int unsigned SUM_W(input int unsigned w);
        return 2 * w + 1;
    endfunction

    // Largest value representable in 'width' bits
    function automatic lim_t lim_max(input int unsigned width, input logic is_signed);
        lim_t one;
        one = lim_t'(1);
        if (is_signed) begin
            return (one <<< (width - 1)) - one;
        end
        return (one <<< width) - one;
    endfunction

    // Smallest value representable in 'width' bits
    function automatic lim_t lim_min(input int unsigned width, input logic is_signed);
        lim_t one;
        one = lim_t'(1);
        if (is_signed) begin
            return -(one <<< (width - 1));
        end
        return lim_t'(0);
    endfunction

    // True when s fits in 'width' bits
    function automatic logic in_range(input lim_t s, input int unsigned width,
                                      input logic is_signed);
        return (s >= lim_min(width, is_signed)) && (s <= lim_max(width, is_signed));
    endfunction

    // Clamp an out-of-range value to the nearest representable limit
    function automatic lim_t sat_value(input lim_t s, input int unsigned width,
                                       input logic is_signed);
        return (s > lim_t'(0)) ? lim_max(width, is_signed) : lim_min(width, is_signed);
    endfunction

endpackage

// File: rtl/mul_add_stage.sv
// One pipeline slice: valid bit plus data word, loaded together when enabled.
module mul_add_stage
    import mul_add_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          vin,
    input  logic [DW-1:0] din,
    output logic          vout,
    output logic [DW-1:0] dout
);

    // Slice register; holds its contents while the pipeline is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vout <= 1'b0;
            dout <= '0;
        end else if (en) begin
            vout <= vin;
            dout <= din;
        end
    end

endmodule

// File: rtl/mul_add_pipe.sv
// Pipelined fused multiply-add: out = a*b + c, signed or unsigned, with a
// global-stall valid/ready pipeline and overflow flag on narrowing.
// Optional feature: define MUL_ADD_SAT_EN to saturate out on overflow instead of wrapping.
module mul_add_pipe
    import mul_add_pkg::*;
#(
    parameter int unsigned W      = 16,
    parameter int unsigned OUT_W  = 32,
    parameter int unsigned STAGES = 3,
    parameter int unsigned SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             ovf
);

    localparam int unsigned S_W   = SUM_W(W);
    localparam int unsigned RES_W = OUT_W + 1;
    localparam int unsigned D0_W  = (STAGES == 1) ? RES_W : 2 * S_W;
    localparam logic        IS_S  = (SIGNED != 0);

    logic              adv;
    logic [STAGES-1:0] v;

    logic              sa;
    logic              sb;
    logic              sc;
    logic [2*W-1:0]    a_x;
    logic [2*W-1:0]    b_x;
    logic [2*W-1:0]    prod;
    logic [S_W-1:0]    p_ext;
    logic [S_W-1:0]    c_ext;
    logic [S_W-1:0]    sum_c;

    lim_t              s_lim;
    logic              ovf_c;
    logic [OUT_W-1:0]  out_c;
    logic [RES_W-1:0]  res_c;

    logic [D0_W-1:0]   d0_in;
    logic [D0_W-1:0]   d0_q;
    logic [RES_W-1:0]  last_q;

    // Global stall: everything moves only when the output slot can drain
    assign adv      = !v[STAGES-1] || out_ready;
    assign in_ready = adv;

    // Operand extension; the low 2W bits of the extended product are exact either way
    assign sa    = IS_S & a[W-1];
    assign sb    = IS_S & b[W-1];
    assign sc    = IS_S & c[W-1];
    assign a_x   = {{W{sa}}, a};
    assign b_x   = {{W{sb}}, b};
    assign prod  = a_x * b_x;
    assign p_ext = {IS_S & prod[2*W-1], prod};
    assign c_ext = {{(W+1){sc}}, c};

    // Exact sum in the limit container for the range check
    assign s_lim = IS_S ? lim_t'($signed(sum_c)) : lim_t'(sum_c);

    // Narrow the exact sum to OUT_W and flag values that do not fit
    always_comb begin
        ovf_c = 1'b0;
        out_c = sum_c[OUT_W-1:0];
        if (OUT_W < S_W) begin
            ovf_c = !in_range(s_lim, OUT_W, IS_S);
`ifdef MUL_ADD_SAT_EN
            if (ovf_c) begin
                out_c = OUT_W'(sat_value(s_lim, OUT_W, IS_S));
            end
`endif
        end
    end

    assign res_c = {ovf_c, out_c};

    mul_add_stage #(.DW(D0_W)) u_stage0 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (adv),
        .vin   (in_valid),
        .din   (d0_in),
        .vout  (v[0]),
        .dout  (d0_q)
    );

    if (STAGES == 1) begin : g_single
        // Multiply, add and narrow all ahead of the only slice
        assign sum_c  = p_ext + c_ext;
        assign d0_in  = res_c;
        assign last_q = d0_q;
    end else begin : g_multi
        logic [RES_W-1:0] res_q [1:STAGES-1];

        // Slice 0 holds the product and extended addend; slice 1 the narrowed result
        assign d0_in = {p_ext, c_ext};
        assign sum_c = d0_q[D0_W-1:S_W] + d0_q[S_W-1:0];

        mul_add_stage #(.DW(RES_W)) u_stage1 (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (adv),
            .vin   (v[0]),
            .din   (res_c),
            .vout  (v[1]),
            .dout  (res_q[1])
        );

        for (genvar k = 2; k < STAGES; k++) begin : g_delay
            mul_add_stage #(.DW(RES_W)) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (adv),
                .vin   (v[k-1]),
                .din   (res_q[k-1]),
                .vout  (v[k]),
                .dout  (res_q[k])
            );
        end

        assign last_q = res_q[STAGES-1];
    end

    assign out_valid = v[STAGES-1];
    assign out       = last_q[OUT_W-1:0];
    assign ovf       = last_q[OUT_W];

endmodule

// File: tb/tb_mul_add_pipe.sv
// Bench for mul_add_pipe: four configurations, a vector table, backpressure,
// mid-operation reset and a random stream on the single-stage build.
module tb_mul_add_pipe;

    localparam int NUM = 4;
    localparam int OW [NUM] = '{32, 32, 16, 20};
    localparam int SG [NUM] = '{0, 1, 0, 1};
    localparam int ST [NUM] = '{3, 3, 2, 1};
    localparam int NV = 15;
`ifdef MUL_ADD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [63:0] out;
        logic        ovf;
    } exp_t;

    typedef struct {
        int          k;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic [63:0] eo;
        logic        eovf;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        iv    [NUM];
    logic        ordy  [NUM];
    logic [15:0] a_i   [NUM];
    logic [15:0] b_i   [NUM];
    logic [15:0] c_i   [NUM];
    logic        ir    [NUM];
    logic        ov    [NUM];
    logic        of    [NUM];
    logic [31:0] out0;
    logic [31:0] out1;
    logic [15:0] out2;
    logic [19:0] out3;
    logic [63:0] obs_out [NUM];

    int   checks;
    int   errors;
    int   pops;
    int   sel;
    exp_t sbq [$];
    exp_t mon_e;
    vec_t vecs [NV];

    assign obs_out[0] = 64'(out0);
    assign obs_out[1] = 64'(out1);
    assign obs_out[2] = 64'(out2);
    assign obs_out[3] = 64'(out3);

    mul_add_pipe #(.W(16), .OUT_W(32), .STAGES(3), .SIGNED(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_i[0]), .b(b_i[0]), .c(c_i[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out(out0), .ovf(of[0]));

    mul_add_pipe #(.W(16), .OUT_W(32), .STAGES(3), .SIGNED(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_i[1]), .b(b_i[1]), .c(c_i[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out(out1), .ovf(of[1]));

    mul_add_pipe #(.W(16), .OUT_W(16), .STAGES(2), .SIGNED(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a_i[2]), .b(b_i[2]), .c(c_i[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out(out2), .ovf(of[2]));

    mul_add_pipe #(.W(16), .OUT_W(20), .STAGES(1), .SIGNED(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
        .a(a_i[3]), .b(b_i[3]), .c(c_i[3]),
        .out_valid(ov[3]), .out_ready(ordy[3]), .out(out3), .ovf(of[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference: exact integer math, then range check and wrap/saturate
    function automatic exp_t model(input int k, input logic [15:0] a, input logic [15:0] b,
                                   input logic [15:0] c);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      sc;
        longint      s;
        longint      lo;
        longint      hi;
        logic [63:0] mask;
        int          ow;
        ow = OW[k];
        if (SG[k] != 0) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sc = longint'($signed(c));
            lo = -(64'sd1 <<< (ow - 1));
            hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        end else begin
            sa = longint'(a);
            sb = longint'(b);
            sc = longint'(c);
            lo = 0;
            hi = (64'sd1 <<< ow) - 64'sd1;
        end
        s     = sa * sb + sc;
        mask  = (64'd1 << ow) - 64'd1;
        e.ovf = (s < lo) || (s > hi);
        if (e.ovf && SAT) e.out = 64'((s > hi) ? hi : lo) & mask;
        else              e.out = 64'(s) & mask;
        return e;
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'hFFFF;
            3:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare every result the selected DUT hands over
    always @(negedge clk) begin
        if (rst_n && ov[sel] && ordy[sel]) begin
            checks++;
            pops++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected dut%0d: got out=%0h ovf=%0b expected no result",
                         sel, obs_out[sel], of[sel]);
            end else begin
                mon_e = sbq.pop_front();
                if (obs_out[sel] !== mon_e.out || of[sel] !== mon_e.ovf) begin
                    errors++;
                    $display("FAIL sb_result dut%0d: got out=%0h ovf=%0b expected out=%0h ovf=%0b",
                             sel, obs_out[sel], of[sel], mon_e.out, mon_e.ovf);
                end
            end
        end
    end

    // Single transaction into an idle pipeline, with latency measurement
    task automatic send_one(input vec_t v);
        int   cnt;
        exp_t e;
        sel = v.k;
        @(posedge clk); #1;
        ordy[v.k] = 1'b1;
        a_i[v.k]  = v.a;
        b_i[v.k]  = v.b;
        c_i[v.k]  = v.c;
        iv[v.k]   = 1'b1;
        @(negedge clk);
        chk($sformatf("idle_in_ready dut%0d", v.k), 64'(ir[v.k]), 64'd1);
        e.out = v.eo;
        e.ovf = v.eovf;
        sbq.push_back(e);
        @(posedge clk); #1;
        iv[v.k] = 1'b0;
        cnt = 0;
        while (!ov[v.k] && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk($sformatf("latency dut%0d", v.k), 64'(cnt), 64'(ST[v.k] - 1));
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        int   idx;
        int   guard;
        int   stale;
        int   sent;
        int   pops0;
        bit   stable;
        bit   acc;
        logic [63:0] hold;
        exp_t ea;

        checks = 0;
        errors = 0;
        pops   = 0;
        sel    = 0;
        rst_n  = 1'b0;
        for (int k = 0; k < NUM; k++) begin
            iv[k]   = 1'b0;
            ordy[k] = 1'b1;
            a_i[k]  = '0;
            b_i[k]  = '0;
            c_i[k]  = '0;
        end

        vecs[0]  = '{0, 16'h0003, 16'h0005, 16'h0007, 64'h16, 1'b0};
        vecs[1]  = '{0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 64'hFFFF0000, 1'b0};
        vecs[2]  = '{0, 16'h0000, 16'h0000, 16'h0000, 64'h0, 1'b0};
        vecs[3]  = '{1, 16'hFFFD, 16'h0005, 16'h0002, 64'hFFFFFFF3, 1'b0};
        vecs[4]  = '{1, 16'h8000, 16'h8000, 16'h7FFF, 64'h40007FFF, 1'b0};
        vecs[5]  = '{1, 16'h8000, 16'h8000, 16'h8000, 64'h3FFF8000, 1'b0};
        vecs[6]  = '{1, 16'h7FFF, 16'h8000, 16'h0000, 64'hC0008000, 1'b0};
        vecs[7]  = '{2, 16'h0100, 16'h0100, 16'h0000, SAT ? 64'hFFFF : 64'h0, 1'b1};
        vecs[8]  = '{2, 16'h00FF, 16'h0100, 16'h00FF, 64'hFFFF, 1'b0};
        vecs[9]  = '{2, 16'h00FF, 16'h0100, 16'h0100, SAT ? 64'hFFFF : 64'h0, 1'b1};
        vecs[10] = '{3, 16'h0800, 16'h0100, 16'h0000, SAT ? 64'h7FFFF : 64'h80000, 1'b1};
        vecs[11] = '{3, 16'hF800, 16'h0100, 16'h0000, 64'h80000, 1'b0};
        vecs[12] = '{3, 16'hF800, 16'h0100, 16'hFFFF, SAT ? 64'h80000 : 64'h7FFFF, 1'b1};
        vecs[13] = '{3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 64'h0, 1'b0};
        vecs[14] = '{3, 16'h03FF, 16'h0200, 16'h01FF, 64'h7FFFF, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < NUM; k++) begin
            chk($sformatf("reset_out_valid dut%0d", k), 64'(ov[k]), 64'd0);
            chk($sformatf("reset_out dut%0d", k), obs_out[k] | 64'(of[k]), 64'd0);
            chk($sformatf("reset_in_ready dut%0d", k), 64'(ir[k]), 64'd1);
        end

        for (int i = 0; i < NV; i++) send_one(vecs[i]);

        // Backpressure on the default build: 3 fit, output holds, then drain in order
        sel = 0;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            a_i[0] = 16'(idx + 1);
            b_i[0] = 16'(idx * 7 + 10);
            c_i[0] = 16'(idx * 3);
            iv[0]  = (idx < 5);
            @(negedge clk);
            if (iv[0] && ir[0]) begin
                sbq.push_back(model(0, a_i[0], b_i[0], c_i[0]));
                idx++;
            end
            @(posedge clk); #1;
        end
        chk("bp_accepted", 64'(idx), 64'd3);
        chk("bp_in_ready_full", 64'(ir[0]), 64'd0);
        hold   = obs_out[0];
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (obs_out[0] !== hold || ov[0] !== 1'b1 || ir[0] !== 1'b0) stable = 1'b0;
        end
        chk("bp_stable", 64'(stable), 64'd1);
        @(posedge clk); #1;
        ordy[0] = 1'b1;
        guard = 0;
        while ((idx < 5 || sbq.size() != 0) && guard < 50) begin
            a_i[0] = 16'(idx + 1);
            b_i[0] = 16'(idx * 7 + 10);
            c_i[0] = 16'(idx * 3);
            iv[0]  = (idx < 5);
            @(negedge clk);
            if (iv[0] && ir[0]) begin
                sbq.push_back(model(0, a_i[0], b_i[0], c_i[0]));
                idx++;
            end
            @(posedge clk); #1;
            guard++;
        end
        iv[0] = 1'b0;
        chk("bp_drained", 64'(sbq.size() + (5 - idx)), 64'd0);

        // Reset with two items in flight
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        a_i[0] = 16'h1234; b_i[0] = 16'h0010; c_i[0] = 16'h0001; iv[0] = 1'b1;
        ea = model(0, a_i[0], b_i[0], c_i[0]);
        @(posedge clk); #1;
        a_i[0] = 16'h0222; b_i[0] = 16'h0003; c_i[0] = 16'h0005;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        chk("rst_pre_valid", 64'(ov[0]), 64'd1);
        chk("rst_pre_out", obs_out[0], ea.out);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(ov[0]), 64'd0);
        chk("rst_out", obs_out[0] | 64'(of[0]), 64'd0);
        sbq.delete();
        @(negedge clk);
        rst_n   = 1'b1;
        ordy[0] = 1'b1;
        #1;
        chk("rst_in_ready", 64'(ir[0]), 64'd1);
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (ov[0]) stale++;
        end
        chk("rst_no_stale", 64'(stale), 64'd0);

        // Random stream with random backpressure on the single-stage signed build
        sel   = 3;
        sent  = 0;
        acc   = 1'b0;
        pops0 = pops;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            if (acc) begin
                iv[3] = 1'b0;
                acc   = 1'b0;
            end
            if (!iv[3] && sent < 150 && $urandom_range(0, 3) != 0) begin
                a_i[3] = pick();
                b_i[3] = pick();
                c_i[3] = pick();
                iv[3]  = 1'b1;
            end
            ordy[3] = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (iv[3] && ir[3]) begin
                sbq.push_back(model(3, a_i[3], b_i[3], c_i[3]));
                sent++;
                acc = 1'b1;
            end
        end
        @(posedge clk); #1;
        iv[3]   = 1'b0;
        ordy[3] = 1'b1;
        guard = 0;
        while (sbq.size() != 0 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("rand_drained", 64'(sbq.size()), 64'd0);
        chk("rand_result_count", 64'(pops - pops0), 64'(sent));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
